// File: rtl/coproc_req_arbiter_pkg.sv
// coproc_pkg: definitions shared by the coprocessor request arbiter and its
// round-robin picker.
//   - FSM state encoding (IDLE/ISSUE/RESP/RELEASE)
//   - value driven on rsp_err_o when the engine never acknowledged
//   - idx_w(): index width for an N-entry requester vector (at least 1 bit)
package coproc_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic RSP_ERR_TIMEOUT = 1'b1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coproc_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin first-set-bit finder.
// Returns the first set bit of req at or after ptr, wrapping modulo N.
// Ports:
//   req  in  N    request vector
//   ptr  in  IW   starting position (0..N-1)
//   vld  out 1    any bit of req set
//   idx  out IW   index of the selected bit (0 when vld is low)
module rr_pick
    import coproc_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          vld,
    output logic [IW-1:0] idx
);

    int j;

    // Scan from the farthest offset down to offset 0 so the closest set bit
    // after ptr is the last assignment and therefore wins.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                vld = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/coproc_req_arbiter.sv
// coproc_req_arbiter: shares one logic-engine req/ack port among NUM_REQ
// requesters. Round-robin grant, one transaction in flight, ack timeout
// converted into an error response.
// Optional feature: define COPROC_ARB_STATS_EN to add wait_cycles_o, a
// per-requester count of cycles spent requesting without holding the grant.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_i              per-requester request level (held until rsp_ack)
//   req_addr_i         packed addresses, slice i for requester i
//   rsp_ack_o          one-cycle response pulse to the winner
//   rsp_data_o         response data, valid with rsp_ack_o, else 0
//   rsp_err_o          response is a timeout, valid with rsp_ack_o
//   eng_req_o          request to the engine
//   eng_addr_o         latched address for the engine
//   eng_ack_i          engine acknowledge (pulse or level)
//   eng_data_i         engine data, sampled with eng_ack_i
//   busy_o             state is not IDLE
//   grant_idx_o        current or last winner
//   op_count_o         completed transactions (wrapping)
//   timeout_count_o    timed-out transactions (saturating)
//   wait_cycles_o      (COPROC_ARB_STATS_EN only) 32-bit wait counters
module coproc_req_arbiter
    import coproc_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    output logic [NUM_REQ-1:0]          rsp_ack_o,
    output logic [DATA_W-1:0]           rsp_data_o,
    output logic                        rsp_err_o,
    output logic                        eng_req_o,
    output logic [ADDR_W-1:0]           eng_addr_o,
    input  logic                        eng_ack_i,
    input  logic [DATA_W-1:0]           eng_data_i,
    output logic                        busy_o,
    output logic [idx_w(NUM_REQ)-1:0]   grant_idx_o,
    output logic [31:0]                 op_count_o,
    output logic [15:0]                 timeout_count_o
`ifdef COPROC_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]       wait_cycles_o
`endif
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = idx_w(TIMEOUT_CYCLES);

    logic [1:0]                         state;
    logic [IW-1:0]                      rr_ptr;
    logic [CW-1:0]                      wait_cnt;
    logic                               pick_vld;
    logic [IW-1:0]                      pick_idx;
    logic [NUM_REQ-1:0][ADDR_W-1:0]     addr_arr;

    assign addr_arr = req_addr_i;
    assign busy_o   = (state != ST_IDLE);

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req (req_i),
        .ptr (rr_ptr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            rr_ptr          <= '0;
            wait_cnt        <= '0;
            rsp_ack_o       <= '0;
            rsp_data_o      <= '0;
            rsp_err_o       <= 1'b0;
            eng_req_o       <= 1'b0;
            eng_addr_o      <= '0;
            grant_idx_o     <= '0;
            op_count_o      <= '0;
            timeout_count_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant_idx_o <= pick_idx;
                        eng_addr_o  <= addr_arr[pick_idx];
                        eng_req_o   <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // wait_cnt holds the number of earlier ISSUE cycles, so the
                    // value TIMEOUT_CYCLES-1 marks the last cycle eng_req_o may
                    // stay high. An ack in that same cycle still takes priority.
                    if (eng_ack_i) begin
                        eng_req_o              <= 1'b0;
                        rsp_data_o             <= eng_data_i;
                        rsp_err_o              <= 1'b0;
                        rsp_ack_o[grant_idx_o] <= 1'b1;
                        state                  <= ST_RESP;
                    end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        eng_req_o              <= 1'b0;
                        rsp_data_o             <= '0;
                        rsp_err_o              <= RSP_ERR_TIMEOUT;
                        rsp_ack_o[grant_idx_o] <= 1'b1;
                        if (timeout_count_o != 16'hFFFF)
                            timeout_count_o <= timeout_count_o + 16'd1;
                        state                  <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_ack_o  <= '0;
                    rsp_data_o <= '0;
                    rsp_err_o  <= 1'b0;
                    op_count_o <= op_count_o + 32'd1;
                    rr_ptr     <= (grant_idx_o == IW'(NUM_REQ - 1)) ? '0
                                                                     : grant_idx_o + 1'b1;
                    state      <= ST_RELEASE;
                end
                default: begin
                    // The winner must drop its level before anyone is picked
                    // again, otherwise a held request would be granted twice.
                    if (!req_i[grant_idx_o])
                        state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef COPROC_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] wait_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_acc <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_i[i] && !(busy_o && (grant_idx_o == IW'(i))))
                    wait_acc[i] <= wait_acc[i] + 32'd1;
            end
        end
    end

    assign wait_cycles_o = wait_acc;
`endif

endmodule

// File: tb/tb_coproc_req_arbiter.sv
module tb_coproc_req_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_i;
    logic [3:0][31:0] addr_arr;
    logic [127:0]  req_addr_i;
    logic [3:0]    rsp_ack_o;
    logic [31:0]   rsp_data_o;
    logic          rsp_err_o;
    logic          eng_req_o;
    logic [31:0]   eng_addr_o;
    logic          eng_ack_i;
    logic [31:0]   eng_data_i;
    logic          busy_o;
    logic [1:0]    grant_idx_o;
    logic [31:0]   op_count_o;
    logic [15:0]   timeout_count_o;
`ifdef COPROC_ARB_STATS_EN
    logic [127:0]  wait_cycles_o;
`endif

    logic          auto_ack;
    logic          man_ack;
    logic [31:0]   man_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign req_addr_i = addr_arr;
    // Auto engine: acks in the first cycle it sees a request, echoing a
    // scrambled address as data.
    assign eng_ack_i  = auto_ack ? eng_req_o : man_ack;
    assign eng_data_i = auto_ack ? (eng_addr_o ^ 32'h5A5A0000) : man_data;

    coproc_req_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .req_i           (req_i),
        .req_addr_i      (req_addr_i),
        .rsp_ack_o       (rsp_ack_o),
        .rsp_data_o      (rsp_data_o),
        .rsp_err_o       (rsp_err_o),
        .eng_req_o       (eng_req_o),
        .eng_addr_o      (eng_addr_o),
        .eng_ack_i       (eng_ack_i),
        .eng_data_i      (eng_data_i),
        .busy_o          (busy_o),
        .grant_idx_o     (grant_idx_o),
        .op_count_o      (op_count_o),
        .timeout_count_o (timeout_count_o)
`ifdef COPROC_ARB_STATS_EN
        ,
        .wait_cycles_o   (wait_cycles_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a response pulse; returns winner, data and error.
    task automatic wait_rsp(output int idx, output logic [31:0] d, output logic e);
        int n;
        n = 0;
        while (rsp_ack_o == 4'b0 && n < 200) begin
            tick;
            n++;
        end
        chk("rsp_seen", {63'b0, rsp_ack_o != 4'b0}, 64'd1);
        chk("rsp_onehot", {63'b0, $onehot(rsp_ack_o)}, 64'd1);
        idx = 0;
        for (int i = 0; i < 4; i++)
            if (rsp_ack_o[i]) idx = i;
        d = rsp_data_o;
        e = rsp_err_o;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx;
        int          n;
        logic [31:0] d;
        logic        e;

        rst      = 1'b1;
        req_i    = 4'b0;
        auto_ack = 1'b0;
        man_ack  = 1'b0;
        man_data = 32'h0;
        addr_arr[0] = 32'h40;
        addr_arr[1] = 32'h140;
        addr_arr[2] = 32'h240;
        addr_arr[3] = 32'h340;
        tick; tick;

        // reset state
        chk("rst_eng_req", {63'b0, eng_req_o}, 64'd0);
        chk("rst_busy", {63'b0, busy_o}, 64'd0);
        chk("rst_rsp_ack", {60'b0, rsp_ack_o}, 64'd0);
        chk("rst_op_count", {32'b0, op_count_o}, 64'd0);
        chk("rst_to_count", {48'b0, timeout_count_o}, 64'd0);
        chk("rst_grant", {62'b0, grant_idx_o}, 64'd0);
        rst = 1'b0;
        tick;

        // single request, ack two cycles after eng_req rises
        req_i = 4'b0001;
        tick;
        chk("single_eng_req", {63'b0, eng_req_o}, 64'd1);
        chk("single_eng_addr", {32'b0, eng_addr_o}, 64'h40);
        chk("single_busy", {63'b0, busy_o}, 64'd1);
        tick;
        chk("single_no_rsp_yet", {60'b0, rsp_ack_o}, 64'd0);
        man_ack  = 1'b1;
        man_data = 32'hABCD1234;
        tick;
        chk("single_rsp_ack", {60'b0, rsp_ack_o}, 64'h1);
        chk("single_rsp_data", {32'b0, rsp_data_o}, 64'hABCD1234);
        chk("single_rsp_err", {63'b0, rsp_err_o}, 64'd0);
        chk("single_eng_req_low", {63'b0, eng_req_o}, 64'd0);
        man_ack = 1'b0;
        req_i   = 4'b0;
        tick;
        chk("single_pulse_end", {60'b0, rsp_ack_o}, 64'd0);
        chk("single_data_clr", {32'b0, rsp_data_o}, 64'd0);
        chk("single_op_count", {32'b0, op_count_o}, 64'd1);
        tick;
        chk("single_idle", {63'b0, busy_o}, 64'd0);

        // fairness: pointer is 1 after requester 0 was served
        auto_ack = 1'b1;
        req_i    = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            int exp_i;
            exp_i = (k + 1) % 4;
            wait_rsp(idx, d, e);
            chk("fair_idx", 64'(idx), 64'(exp_i));
            chk("fair_data", {32'b0, d}, {32'b0, addr_arr[exp_i] ^ 32'h5A5A0000});
            req_i[idx] = 1'b0;
            tick;
        end
        tick; tick;
        // last served was 0, so 1 is next in line
        req_i = 4'b0011;
        wait_rsp(idx, d, e);
        chk("fair_reraise", 64'(idx), 64'd1);
        req_i = 4'b0;
        tick; tick;
        chk("fair_op_count", {32'b0, op_count_o}, 64'd6);

        // timeout: engine never acks
        auto_ack = 1'b0;
        req_i    = 4'b0100;
        tick;
        n = 0;
        while (eng_req_o && n < 200) begin
            n++;
            tick;
        end
        chk("to_req_cycles", 64'(n), 64'd64);
        chk("to_rsp_ack", {60'b0, rsp_ack_o}, 64'h4);
        chk("to_rsp_err", {63'b0, rsp_err_o}, 64'd1);
        chk("to_rsp_data", {32'b0, rsp_data_o}, 64'd0);
        chk("to_count", {48'b0, timeout_count_o}, 64'd1);
        req_i = 4'b0;
        tick; tick;
        chk("to_op_count", {32'b0, op_count_o}, 64'd7);

        // ack on the last cycle before timeout expiry
        req_i = 4'b1000;
        tick;
        for (int k = 0; k < 63; k++) tick;
        chk("bnd_still_req", {63'b0, eng_req_o}, 64'd1);
        man_ack  = 1'b1;
        man_data = 32'h0BADF00D;
        tick;
        man_ack = 1'b0;
        chk("bnd_rsp_ack", {60'b0, rsp_ack_o}, 64'h8);
        chk("bnd_rsp_err", {63'b0, rsp_err_o}, 64'd0);
        chk("bnd_rsp_data", {32'b0, rsp_data_o}, 64'h0BADF00D);
        chk("bnd_to_count", {48'b0, timeout_count_o}, 64'd1);
        req_i = 4'b0;
        tick; tick;

        // held request: pointer is 0; requester 2 keeps its level 5 cycles
        auto_ack = 1'b1;
        req_i    = 4'b1100;
        wait_rsp(idx, d, e);
        chk("held_first", 64'(idx), 64'd2);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("held_no_regrant", {63'b0, eng_req_o}, 64'd0);
            chk("held_no_rsp", {60'b0, rsp_ack_o}, 64'd0);
        end
        req_i[2] = 1'b0;
        wait_rsp(idx, d, e);
        chk("held_next", 64'(idx), 64'd3);
        req_i = 4'b0;
        tick; tick;

        // move pointer to 2, then reset in the middle of an ISSUE wait
        req_i = 4'b0010;
        wait_rsp(idx, d, e);
        chk("pre_rst_idx", 64'(idx), 64'd1);
        req_i = 4'b0;
        tick; tick;
        auto_ack = 1'b0;
        req_i    = 4'b1000;
        tick;
        chk("mid_eng_req", {63'b0, eng_req_o}, 64'd1);
        chk("mid_grant", {62'b0, grant_idx_o}, 64'd3);
        tick; tick; tick;
        rst = 1'b1;
        tick;
        chk("rst_mid_eng_req", {63'b0, eng_req_o}, 64'd0);
        chk("rst_mid_rsp_ack", {60'b0, rsp_ack_o}, 64'd0);
        chk("rst_mid_op", {32'b0, op_count_o}, 64'd0);
        chk("rst_mid_to", {48'b0, timeout_count_o}, 64'd0);
        rst   = 1'b0;
        req_i = 4'b1001;
        tick;
        chk("post_rst_grant", {62'b0, grant_idx_o}, 64'd0);
        chk("post_rst_addr", {32'b0, eng_addr_o}, 64'h40);
        chk("post_rst_no_rsp", {60'b0, rsp_ack_o}, 64'd0);
        auto_ack = 1'b1;
        wait_rsp(idx, d, e);
        chk("post_rst_idx", 64'(idx), 64'd0);
        req_i = 4'b0;
        tick; tick;
        chk("post_rst_op", {32'b0, op_count_o}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
